// File: rtl/regfile_param.sv
// Parametrised register file: one synchronous write port, NUM_RD combinational
// read ports, optional write-to-read bypass, optional hard-wired zero entry,
// and a clear sweep that zeroes the array one entry per clock.
//
// state | meaning
// IDLE  | normal operation, waiting for clr_req
// SWEEP | clearing entry ptr on every edge, ptr counts 0..DEPTH-1
module regfile_param #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       clr_req,
    output logic                       busy,
    output logic                       clr_done
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  ptr;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               wr_accept;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_EXT);
    endfunction

    function automatic logic is_zero_entry(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // The sweep owns entry ptr this cycle, so a write there loses to the clear.
    assign wr_accept = wr_en
                     && in_range(wr_addr)
                     && !is_zero_entry(wr_addr)
                     && !(busy && (wr_addr == ptr));

    // Clear-sweep sequencer; busy and clr_done are registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state <= SWEEP;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (ptr == LAST) begin
                        state    <= IDLE;
                        ptr      <= '0;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ptr      <= '0;
                    busy     <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Storage: accepted writes land on the edge, the sweep clears entry ptr after them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_accept) begin
                mem[wr_addr] <= wr_data;
            end
            if (busy) begin
                mem[ptr] <= '0;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_val;

        assign ra = rd_addr[p*ADDR_W +: ADDR_W];

        // Read mux: out-of-range and zero entry first, then bypass, then storage.
        always_comb begin
            if (!in_range(ra)) begin
                rd_val = '0;
            end else if (is_zero_entry(ra)) begin
                rd_val = '0;
            end else if ((BYPASS != 0) && wr_accept && (ra == wr_addr)) begin
                rd_val = wr_data;
            end else begin
                rd_val = mem[ra];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = rd_val;
    end

endmodule
